fpu: RTL and testbench

FPU -- requirements
Module: fpu

---
 rtl/fpu.sv | 171 +++++++++++++++++
 tb/tb_fpu.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu.sv
// Single-cycle IEEE-754 binary32 FPU: ADD, SUB, MUL, DIV with round-to-nearest-even.
// Subnormals are read as zero and underflow flushes to signed zero.
module fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        ready
);

    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_MUL = 3'b010;
    localparam logic [2:0]  OP_DIV = 3'b011;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    logic [31:0] result_q, result_d;
    logic        ready_q;
    logic [31:0] b_eff;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic logic signed [11:0] uexp(input logic [7:0] e);
        return $signed({4'b0, e});
    endfunction

    // m = {1.mantissa[23:0], guard, round, sticky}; e is the biased exponent
    function automatic logic [31:0] pack(
        input logic               s,
        input logic signed [11:0] e,
        input logic [26:0]        m
    );
        logic               up;
        logic [24:0]        mr;
        logic signed [11:0] er;
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[26:3]} + {24'b0, up};
        er = e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 12'sd1;
        end
        if (er > 12'sd254) return {s, 8'hFF, 23'b0};
        if (er < 12'sd1 || !mr[23]) return {s, 31'b0};
        return {s, er[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        hi, lo;
        logic [7:0]         d;
        logic [53:0]        sh;
        logic [26:0]        mh, ml, m;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic signed [11:0] e;
        if (is_nan(x) || is_nan(y)) return QNAN;
        if (is_inf(x) && is_inf(y)) return (x[31] != y[31]) ? QNAN : x;
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        if (is_zero(x) && is_zero(y)) return {x[31] & y[31], 31'b0};
        if (is_zero(x)) return y;
        if (is_zero(y)) return x;
        hi  = (y[30:0] > x[30:0]) ? y : x;
        lo  = (y[30:0] > x[30:0]) ? x : y;
        d   = hi[30:23] - lo[30:23];
        mh  = {1'b1, hi[22:0], 3'b0};
        sh  = {1'b1, lo[22:0], 3'b0, 27'b0} >> d;
        // bits shifted past the round position collapse into sticky
        ml  = (d > 8'd26) ? 27'd1 : (sh[53:27] | {26'b0, |sh[26:0]});
        sum = (hi[31] == lo[31]) ? ({1'b0, mh} + {1'b0, ml})
                                 : ({1'b0, mh} - {1'b0, ml});
        e   = uexp(hi[30:23]);
        if (sum == 28'd0) return 32'h0;
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = e + 12'sd1;
        end else begin
            lz = 5'd0;
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 5'(26 - i);
            m = sum[26:0] << lz;
            e = e - $signed({7'b0, lz});
        end
        return pack(hi[31], e, m);
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [47:0]        p;
        logic [26:0]        m;
        logic signed [11:0] e;
        s = x[31] ^ y[31];
        if (is_nan(x) || is_nan(y)) return QNAN;
        if ((is_inf(x) && is_zero(y)) || (is_zero(x) && is_inf(y))) return QNAN;
        if (is_inf(x) || is_inf(y)) return {s, 8'hFF, 23'b0};
        if (is_zero(x) || is_zero(y)) return {s, 31'b0};
        p = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
        e = uexp(x[30:23]) + uexp(y[30:23]) - 12'sd127;
        if (p[47]) begin
            m = {p[47:22], |p[21:0]};
            e = e + 12'sd1;
        end else begin
            m = {p[46:21], |p[20:0]};
        end
        return pack(s, e, m);
    endfunction

    function automatic logic [31:0] f_div(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [49:0]        num, den;
        logic [26:0]        q;
        logic               rnz;
        logic [26:0]        m;
        logic signed [11:0] e;
        s = x[31] ^ y[31];
        if (is_nan(x) || is_nan(y)) return QNAN;
        if (is_inf(x) && is_inf(y)) return QNAN;
        if (is_zero(x) && is_zero(y)) return QNAN;
        if (is_inf(x) || is_zero(y)) return {s, 8'hFF, 23'b0};
        if (is_inf(y) || is_zero(x)) return {s, 31'b0};
        num = {1'b1, x[22:0], 26'b0};
        den = {26'b0, 1'b1, y[22:0]};
        q   = 27'(num / den);
        rnz = (num % den) != 50'd0;
        e   = uexp(x[30:23]) - uexp(y[30:23]) + 12'sd127;
        if (q[26]) begin
            m = {q[26:1], q[0] | rnz};
        end else begin
            m = {q[25:0], rnz};
            e = e - 12'sd1;
        end
        return pack(s, e, m);
    endfunction

    always_comb begin
        b_eff    = {b[31] ^ op[0], b[30:0]};
        result_d = 32'h0;
        unique case (op)
            OP_ADD, OP_SUB: result_d = f_add(a, b_eff);
            OP_MUL:         result_d = f_mul(a, b);
            OP_DIV:         result_d = f_div(a, b);
            default:        result_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'h0;
            ready_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            ready_q  <= 1'b1;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_fpu.sv
// Scoreboard bench for fpu: expected words are queued when operands
// are driven and popped one cycle later when the registered result appears.
module tb_fpu;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = 32'h0;
    logic [31:0] b   = 32'h0;
    logic [2:0]  op  = 3'b000;
    logic [31:0] result;
    logic        ready;

    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    fpu dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .op    (op),
        .result(result),
        .ready (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic test_reset;
        logic [31:0] ev;
        rst = 1'b1;
        a = 32'h0; b = 32'h0; op = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h, want 00000000", result);
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b, want 0", ready);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(32'h0);
        @(posedge clk);
        #1;
        ev = sb.pop_front();
        n_cmp++;
        if (result !== ev || ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first: got %h/%b, want %h/1", result, ready, ev);
        end
    endtask

    task automatic test_addsub;
        vec_t v [9] = '{
            '{32'h40000000, 32'h40400000, 3'b000, 32'h40A00000},
            '{32'h40800000, 32'h40000000, 3'b001, 32'h40000000},
            '{32'h3F800000, 32'hBF000000, 3'b000, 32'h3F000000},
            '{32'h3F800000, 32'h3F800000, 3'b001, 32'h00000000},
            '{32'h80000000, 32'h80000000, 3'b000, 32'h80000000},
            '{32'h80000000, 32'h00000000, 3'b001, 32'h80000000},
            '{32'h00000001, 32'h00000000, 3'b000, 32'h00000000},
            '{32'h3F800000, 32'h00000000, 3'b000, 32'h3F800000},
            '{32'hC0400000, 32'h3F800000, 3'b000, 32'hC0000000}
        };
        logic [31:0] ev;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; op = v[i].op;
            sb.push_back(v[i].r);
            @(posedge clk);
            #1;
            ev = sb.pop_front();
            n_cmp++;
            if (result !== ev || ready !== 1'b1) begin
                n_err++;
                $display("FAIL addsub[%0d]: got %h/%b, want %h/1", i, result, ready, ev);
            end
        end
    endtask

    task automatic test_mul;
        vec_t v [5] = '{
            '{32'h40400000, 32'h40000000, 3'b010, 32'h40C00000},
            '{32'h3FC00000, 32'h3FC00000, 3'b010, 32'h40100000},
            '{32'hC0000000, 32'h40400000, 3'b010, 32'hC0C00000},
            '{32'h00800000, 32'h3F000000, 3'b010, 32'h00000000},
            '{32'h00400000, 32'h3F800000, 3'b010, 32'h00000000}
        };
        logic [31:0] ev;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; op = v[i].op;
            sb.push_back(v[i].r);
            @(posedge clk);
            #1;
            ev = sb.pop_front();
            n_cmp++;
            if (result !== ev || ready !== 1'b1) begin
                n_err++;
                $display("FAIL mul[%0d]: got %h/%b, want %h/1", i, result, ready, ev);
            end
        end
    endtask

    task automatic test_div;
        vec_t v [5] = '{
            '{32'h40800000, 32'h40000000, 3'b011, 32'h40000000},
            '{32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB},
            '{32'hC0C00000, 32'h40000000, 3'b011, 32'hC0400000},
            '{32'h3F800000, 32'h00000000, 3'b011, 32'h7F800000},
            '{32'hBF800000, 32'h00000000, 3'b011, 32'hFF800000}
        };
        logic [31:0] ev;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; op = v[i].op;
            sb.push_back(v[i].r);
            @(posedge clk);
            #1;
            ev = sb.pop_front();
            n_cmp++;
            if (result !== ev || ready !== 1'b1) begin
                n_err++;
                $display("FAIL div[%0d]: got %h/%b, want %h/1", i, result, ready, ev);
            end
        end
    endtask

    task automatic test_specials;
        vec_t v [10] = '{
            '{32'h00000000, 32'h00000000, 3'b011, 32'h7FC00000},
            '{32'h7F800000, 32'hFF800000, 3'b000, 32'h7FC00000},
            '{32'h7F800000, 32'h7F800000, 3'b001, 32'h7FC00000},
            '{32'h3F800000, 32'hBF800000, 3'b000, 32'h00000000},
            '{32'h00000000, 32'h7F800000, 3'b010, 32'h7FC00000},
            '{32'h7F800000, 32'h7F800000, 3'b011, 32'h7FC00000},
            '{32'hBF800000, 32'h7F800000, 3'b011, 32'h80000000},
            '{32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000},
            '{32'hFF800000, 32'h3F800000, 3'b000, 32'hFF800000},
            '{32'h7F800000, 32'hC0000000, 3'b010, 32'hFF800000}
        };
        logic [31:0] ev;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; op = v[i].op;
            sb.push_back(v[i].r);
            @(posedge clk);
            #1;
            ev = sb.pop_front();
            n_cmp++;
            if (result !== ev || ready !== 1'b1) begin
                n_err++;
                $display("FAIL special[%0d]: got %h/%b, want %h/1", i, result, ready, ev);
            end
        end
    endtask

    task automatic test_rounding;
        vec_t v [5] = '{
            '{32'h3F800000, 32'h33800000, 3'b000, 32'h3F800000},
            '{32'h3F800001, 32'h33800000, 3'b000, 32'h3F800002},
            '{32'h7F7FFFFF, 32'h40000000, 3'b010, 32'h7F800000},
            '{32'hFF7FFFFF, 32'h40000000, 3'b010, 32'hFF800000},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 32'h7F800000}
        };
        logic [31:0] ev;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = v[i].a; b = v[i].b; op = v[i].op;
            sb.push_back(v[i].r);
            @(posedge clk);
            #1;
            ev = sb.pop_front();
            n_cmp++;
            if (result !== ev || ready !== 1'b1) begin
                n_err++;
                $display("FAIL round[%0d]: got %h/%b, want %h/1", i, result, ready, ev);
            end
        end
    endtask

    task automatic test_reserved;
        logic [31:0] ev;
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            a = 32'h3F800000; b = 32'h3F800000; op = 3'(i);
            sb.push_back(32'h0);
            @(posedge clk);
            #1;
            ev = sb.pop_front();
            n_cmp++;
            if (result !== ev || ready !== 1'b1) begin
                n_err++;
                $display("FAIL reserved[%0d]: got %h/%b, want %h/1", i, result, ready, ev);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ev;
        @(negedge clk);
        a = 32'h40000000; b = 32'h40400000; op = 3'b000;
        sb.push_back(32'h40A00000);
        @(posedge clk);
        #1;
        a = 32'h3F800000; op = 3'b010;
        sb.push_back(32'h40400000);
        #2;
        ev = sb.pop_front();
        n_cmp++;
        if (result !== ev) begin
            n_err++;
            $display("FAIL hold_between_edges: got %h, want %h", result, ev);
        end
        @(posedge clk);
        #1;
        ev = sb.pop_front();
        n_cmp++;
        if (result !== ev || ready !== 1'b1) begin
            n_err++;
            $display("FAIL next_edge: got %h/%b, want %h/1", result, ready, ev);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ev;
        @(negedge clk);
        a = 32'h40800000; b = 32'h40000000; op = 3'b011;
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        n_cmp++;
        if (result !== 32'h0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got %h/%b, want 00000000/0", result, ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (result !== 32'h0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: got %h/%b, want 00000000/0", result, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        a = 32'h40400000; b = 32'h40000000; op = 3'b010;
        sb.push_back(32'h40C00000);
        @(posedge clk);
        #1;
        ev = sb.pop_front();
        n_cmp++;
        if (result !== ev || ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got %h/%b, want %h/1", result, ready, ev);
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_specials();
        test_rounding();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
